// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one imem read at a time and
// presents {pc, instr, pc+4} to decode. Optional macro: PC_MISALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;

  logic        redir_take;
  logic [31:0] redir_target;
  logic [31:0] pc_plus4;

  assign pc_plus4     = pc_q + 32'd4;
  assign redir_target = redirect_pc & ~32'h0000_0003;

`ifdef PC_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  logic redir_bad;

  // A misaligned target is rejected outright; the flag is sticky until reset.
  assign redir_bad        = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_take       = redirect_valid && !redir_bad;
  assign misaligned_d     = misaligned_q | redir_bad;
  assign fetch_misaligned = misaligned_q;

  always_ff @(posedge clk) begin
    if (rst) misaligned_q <= 1'b0;
    else     misaligned_q <= misaligned_d;
  end
`else
  assign redir_take = redirect_valid;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    if_pc_plus4_d = if_pc_plus4_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redir_take) pc_d = redir_target;
      end
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
        if (redir_take) begin
          pc_d = redir_target;
          // Request already accepted: its response belongs to the wrong path.
          if (imem_req_ready) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redir_take) begin
          pc_d = redir_target;
          if (imem_resp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            if_valid_d    = 1'b1;
            if_pc_d       = pc_q;
            if_instr_d    = imem_resp_data;
            if_pc_plus4_d = pc_plus4;
            pc_d          = pc_plus4;
            state_d       = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redir_take) begin
          if_valid_d = 1'b0;
          pc_d       = redir_target;
          state_d    = S_REQ;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Request outputs are registered from the next-state view, so a redirect
    // taken this cycle is what the memory sees next cycle.
    req_valid_d = (state_d == S_REQ);
    req_addr_d  = pc_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0000_0000;
      if_instr_q    <= NOP_INSTR;
      if_pc_plus4_q <= 32'h0000_0004;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_plus4_q <= if_pc_plus4_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign if_pc_plus4    = if_pc_plus4_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a 1-cycle memory model plus request and
// presentation scoreboards. Honors PC_MISALIGN_CHECK_EN like the design.
module tb_pc_fetch_unit;

  localparam logic [31:0] K   = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
`ifdef PC_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  pc_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_pc_plus4     (if_pc_plus4)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] plus4;
  } if_exp_t;

  logic [31:0] exp_req_q[$];
  if_exp_t     exp_if_q[$];

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          n_present = 0;
  bit          prev_valid = 1'b0;
  bit          pend       = 1'b0;
  bit          mem_hold   = 1'b0;
  logic [31:0] pend_addr  = 32'h0;
  logic [31:0] next_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expect a fetch of addr that is presented to decode.
  task automatic push_fetch(input logic [31:0] addr);
    if_exp_t e;
    e.pc    = addr;
    e.instr = addr ^ K;
    e.plus4 = addr + 32'd4;
    exp_req_q.push_back(addr);
    exp_if_q.push_back(e);
  endtask

  // One clock: enters and leaves on a falling edge. Plays the memory and
  // scores accepted requests and new presentations.
  task automatic cycle();
    bit    deliver;
    bit    accept;
    if_exp_t e;
    deliver         = pend && !mem_hold;
    imem_resp_valid = deliver;
    imem_resp_data  = deliver ? (pend_addr ^ K) : 32'h0;
    accept          = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1);
    if (accept) begin
      check("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
      if (exp_req_q.size() != 0) check("req_addr", imem_req_addr, exp_req_q.pop_front());
      pend_addr = imem_req_addr;
    end
    pend = (pend && !deliver) || accept;
    @(posedge clk);
    @(negedge clk);
    if (if_valid === 1'b1 && !prev_valid) begin
      n_present++;
      check("present_expected", 32'(exp_if_q.size() != 0), 32'd1);
      if (exp_if_q.size() != 0) begin
        e = exp_if_q.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_instr", if_instr, e.instr);
        check("if_pc_plus4", if_pc_plus4, e.plus4);
      end
    end
    prev_valid = (if_valid === 1'b1);
  endtask

  task automatic wait_present(input int max_cycles);
    int start;
    int k;
    start = n_present;
    k     = 0;
    while (n_present == start && k < max_cycles) begin
      cycle();
      k++;
    end
    check("present_seen", 32'(n_present - start), 32'd1);
  endtask

  task automatic redirect_cycle(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_if_pc_plus4", if_pc_plus4, 32'h4);
`ifdef PC_MISALIGN_CHECK_EN
    check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    if_ready        = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    check_reset_outputs();
    rst = 1'b0;

    // Free run: 0x0 presented, then a decode stall on 0x4.
    push_fetch(32'h0);
    push_fetch(32'h4);
    wait_present(10);
    cycle();
    if_ready = 1'b0;
    wait_present(10);
    for (int i = 0; i < 5; i++) begin
      check("stall_if_valid", 32'(if_valid), 32'd1);
      check("stall_if_pc", if_pc, 32'h4);
      check("stall_if_instr", if_instr, 32'h4 ^ K);
      check("stall_no_req", 32'(imem_req_valid), 32'd0);
      cycle();
    end
    if_ready = 1'b1;
    cycle();
    check("release_if_valid", 32'(if_valid), 32'd0);
    check("release_req_valid", 32'(imem_req_valid), 32'd1);
    check("release_req_addr", imem_req_addr, 32'h8);

    // Redirect while waiting on 0x8; its late response is dropped.
    exp_req_q.push_back(32'h8);
    mem_hold = 1'b1;
    cycle();
    redirect_cycle(32'h100);
    mem_hold = 1'b0;
    cycle();
    check("drop_if_valid", 32'(if_valid), 32'd0);
    check("drop_next_addr", imem_req_addr, 32'h100);
    push_fetch(32'h100);
    wait_present(10);
    cycle();

    // Redirect in the same cycle the request is accepted.
    exp_req_q.push_back(32'h104);
    redirect_cycle(32'h200);
    cycle();
    check("accept_redir_if_valid", 32'(if_valid), 32'd0);
    push_fetch(32'h200);
    wait_present(10);
    cycle();

    // Redirect coinciding with the response.
    exp_req_q.push_back(32'h204);
    cycle();
    redirect_cycle(32'h300);
    check("resp_redir_if_valid", 32'(if_valid), 32'd0);
    check("resp_redir_addr", imem_req_addr, 32'h300);
    push_fetch(32'h300);
    wait_present(10);
    cycle();

    // Redirect during HOLD to the top of the address space; pc+4 wraps.
    if_ready = 1'b0;
    push_fetch(32'h304);
    wait_present(10);
    redirect_cycle(32'hFFFF_FFFC);
    check("hold_redir_if_valid", 32'(if_valid), 32'd0);
    check("hold_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
    if_ready = 1'b1;
    push_fetch(32'hFFFF_FFFC);
    wait_present(10);
    cycle();
    check("wrap_next_addr", imem_req_addr, 32'h0);
    push_fetch(32'h0);
    wait_present(10);

    // Redirect while the request is not accepted.
    imem_req_ready = 1'b0;
    cycle();
    check("noready_addr", imem_req_addr, 32'h4);
    redirect_cycle(32'h400);
    check("noready_redir_valid", 32'(imem_req_valid), 32'd1);
    check("noready_redir_addr", imem_req_addr, 32'h400);
    imem_req_ready = 1'b1;
    push_fetch(32'h400);
    wait_present(10);

    // Misaligned redirect.
    imem_req_ready = 1'b0;
    cycle();
    redirect_cycle(32'h502);
`ifdef PC_MISALIGN_CHECK_EN
    check("misalign_addr", imem_req_addr, 32'h404);
    check("misalign_flag", 32'(fetch_misaligned), 32'd1);
    push_fetch(32'h404);
    next_addr = 32'h408;
`else
    check("misalign_addr", imem_req_addr, 32'h500);
    push_fetch(32'h500);
    next_addr = 32'h504;
`endif
    imem_req_ready = 1'b1;
    wait_present(10);
    cycle();
`ifdef PC_MISALIGN_CHECK_EN
    check("misalign_sticky", 32'(fetch_misaligned), 32'd1);
`endif

    // Reset while waiting; the response arrives after reset and is ignored.
    exp_req_q.push_back(next_addr);
    cycle();
    mem_hold = 1'b1;
    rst      = 1'b1;
    cycle();
    check_reset_outputs();
    rst      = 1'b0;
    mem_hold = 1'b0;
    cycle();
    check("late_resp_if_valid", 32'(if_valid), 32'd0);
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_req_addr", imem_req_addr, 32'h0);
    push_fetch(32'h0);
    wait_present(10);
    cycle();

    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    check("if_queue_drained", 32'(exp_if_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
